restoring_divider: RTL

- Iterative unsigned restoring divider. It is the inverse datapath companion to the team's array multiplier.
- Accepts a DATAWIDTH-bit dividend and divisor through a valid/ready handshake.
- Produces one quotient bit per clock and returns the quotient and remainder with a single-cycle o_valid pulse.
- Sits beside the multiplier in the arithmetic test harness and is used to check multiplier results (A*B / B == A).

---
 rtl/restoring_divider.sv | 107 ++++++++++
 1 files changed

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : restoring_divider
//  Purpose  : Iterative unsigned restoring divider, one quotient bit per clock,
//             valid/ready operand intake and a single-cycle o_valid result pulse.
//  Revision : 1.0  initial release
// ============================================================================
module restoring_divider #(
  parameter int DATAWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic                 o_valid,
  output logic [DATAWIDTH-1:0] Q,
  output logic [DATAWIDTH-1:0] R,
  output logic                 div_by_zero
);

  localparam int CNT_W = $clog2(DATAWIDTH + 1);
  localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATAWIDTH-1:0] r_dividend;
  logic [DATAWIDTH-1:0] r_divisor;
  logic [DATAWIDTH:0]   r_rem;
  logic                 r_dbz_pend;
  logic                 r_valid;
  logic [DATAWIDTH-1:0] r_q;
  logic [DATAWIDTH-1:0] r_r;
  logic                 r_dbz;

  logic [DATAWIDTH:0]   w_rem_shift;
  logic [DATAWIDTH:0]   w_rem_sub;
  logic                 w_ge;
  logic [DATAWIDTH:0]   w_rem_next;

  // The extra remainder bit keeps the trial subtraction free of overflow.
  assign w_rem_shift = (r_rem << 1) | {{DATAWIDTH{1'b0}}, r_dividend[DATAWIDTH-1]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_divisor};
  assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_next  = w_ge ? w_rem_sub : w_rem_shift;

  assign i_ready     = !rst && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign o_valid     = r_valid;
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;

  // The dividend register doubles as the quotient: bits leave at the MSB
  // while quotient bits enter at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_dbz_pend <= 1'b0;
      r_valid    <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_valid) begin
            r_dividend <= A;
            r_divisor  <= B;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_dbz_pend <= (B == '0);
            r_state    <= S_BUSY;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_rem      <= w_rem_next;
          r_dividend <= {r_dividend[DATAWIDTH-2:0], w_ge};
          r_cnt      <= r_cnt + CNT_W'(1);
          if (r_cnt == c_LAST_STEP) begin
            r_q     <= {r_dividend[DATAWIDTH-2:0], w_ge};
            r_r     <= w_rem_next[DATAWIDTH-1:0];
            r_dbz   <= r_dbz_pend;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
